// File: rtl/shift_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared mode codes and FSM state encoding for the sequential
//            shifter (deslocador_seq) and its combinational step unit.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Shift mode codes, as presented on the mode port
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : shift_step
// Purpose  : One-position shift/rotate of a WIDTH-bit word in one of four
//            modes (LSL, LSR, ASR, ROL). Also reports the bit that leaves.
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] w_next,
  output logic             bit_out
);

  // Select the single-position move and the bit it pushes out
  always_comb begin
    w_next  = w;
    bit_out = 1'b0;
    case (mode)
      MODE_LSL: begin
        w_next  = {w[WIDTH-2:0], 1'b0};
        bit_out = w[WIDTH-1];
      end
      MODE_LSR: begin
        w_next  = {1'b0, w[WIDTH-1:1]};
        bit_out = w[0];
      end
      MODE_ASR: begin
        w_next  = {w[WIDTH-1], w[WIDTH-1:1]};
        bit_out = w[0];
      end
      MODE_ROL: begin
        w_next  = {w[WIDTH-2:0], w[WIDTH-1]};
        bit_out = w[WIDTH-1];
      end
      default: begin
        w_next  = w;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/deslocador_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : deslocador_seq
// Purpose  : Multi-cycle variable shifter (LSL/LSR/ASR/ROL), one bit position
//            per clock, with start/busy/done handshake and abort.
// Revision : 1.0 - initial release
// ============================================================================
module deslocador_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y,
  output logic               carry,
  output logic               zero
);

  localparam int                 c_LOG_W     = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] c_WIDTH_CNT = SHAMT_W'(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_work;
  logic [1:0]           r_mode;
  logic [SHAMT_W-1:0]   r_cnt;
  logic                 r_carry_int;
  logic [WIDTH-1:0]     r_y;
  logic                 r_carry;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_finish;
  logic                 w_step_en;
  logic [SHAMT_W-1:0]   w_cnt_init;
  logic [WIDTH-1:0]     w_step_word;
  logic                 w_step_bit;

  assign w_accept  = (r_state == ST_IDLE) && start && !abort;
  // abort takes priority over completion: a killed operation never reports done
  assign w_finish  = (r_state == ST_RUN) && !abort && (r_cnt == '0);
  assign w_step_en = (r_state == ST_RUN) && !abort && (r_cnt != '0);

  // Effective iteration count: rotations wrap, plain shifts saturate at WIDTH
  always_comb begin
    w_cnt_init = shamt;
    if (mode == MODE_ROL) begin
      w_cnt_init = SHAMT_W'(shamt[c_LOG_W-1:0]);
    end else if (shamt > c_WIDTH_CNT) begin
      w_cnt_init = c_WIDTH_CNT;
    end
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .w       (r_work),
    .mode    (r_mode),
    .w_next  (w_step_word),
    .bit_out (w_step_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave RUN on completion or abort
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (abort || (r_cnt == '0)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, step while counting, publish result on finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_mode      <= MODE_LSL;
      r_cnt       <= '0;
      r_carry_int <= 1'b0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_work      <= a;
        r_mode      <= mode;
        r_cnt       <= w_cnt_init;
        r_carry_int <= 1'b0;
      end else if (w_step_en) begin
        r_work      <= w_step_word;
        r_carry_int <= w_step_bit;
        r_cnt       <= r_cnt - SHAMT_W'(1);
      end
      if (w_finish) begin
        r_y     <= r_work;
        r_carry <= r_carry_int;
      end
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;
  assign y     = r_y;
  assign carry = r_carry;
  assign zero  = (r_y == '0);

endmodule
`default_nettype wire

// File: tb/tb_deslocador_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_deslocador_seq
// Purpose  : Directed, table-driven self-checking bench for deslocador_seq,
//            plus hand-written abort/reset/back-to-back sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deslocador_seq;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   y;
  logic               carry;
  logic               zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   mode;
    logic [15:0]  a;
    logic [4:0]   shamt;
    logic [15:0]  y;
    logic         c;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  deslocador_seq #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .mode  (mode),
    .a     (a),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present an operation and hold start across one rising edge
  task automatic launch(input logic [1:0] m, input logic [15:0] d, input logic [4:0] s);
    mode  = m;
    a     = d;
    shamt = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; lat = -1 if the budget expires
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{2'b00, 16'h0001, 5'd3,  16'h0008, 1'b0, 1'b0, 4};
    vecs[1]  = '{2'b01, 16'h8001, 5'd1,  16'h4000, 1'b1, 1'b0, 2};
    vecs[2]  = '{2'b10, 16'h8000, 5'd4,  16'hF800, 1'b0, 1'b0, 5};
    vecs[3]  = '{2'b11, 16'h8001, 5'd17, 16'h0003, 1'b1, 1'b0, 2};
    vecs[4]  = '{2'b11, 16'h1234, 5'd0,  16'h1234, 1'b0, 1'b0, 1};
    vecs[5]  = '{2'b00, 16'hFFFF, 5'd20, 16'h0000, 1'b1, 1'b1, 17};
    vecs[6]  = '{2'b10, 16'h8000, 5'd31, 16'hFFFF, 1'b1, 1'b0, 17};
    vecs[7]  = '{2'b01, 16'h00F0, 5'd4,  16'h000F, 1'b0, 1'b0, 5};
    vecs[8]  = '{2'b01, 16'h0001, 5'd16, 16'h0000, 1'b0, 1'b1, 17};
    vecs[9]  = '{2'b11, 16'h8001, 5'd16, 16'h8001, 1'b0, 1'b0, 1};
    vecs[10] = '{2'b01, 16'h8000, 5'd15, 16'h0001, 1'b0, 1'b0, 16};
    vecs[11] = '{2'b11, 16'h1234, 5'd4,  16'h2341, 1'b1, 1'b0, 5};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;
    a     = '0;
    shamt = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",  busy,  0);
    chk("reset done",  done,  0);
    chk("reset y",     y,     0);
    chk("reset carry", carry, 0);
    chk("reset zero",  zero,  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven operations
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].mode, vecs[i].a, vecs[i].shamt);
      chk($sformatf("v%0d busy after accept", i), busy, 1);
      wait_done(lat);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d y", i), y, vecs[i].y);
      chk($sformatf("v%0d carry", i), carry, vecs[i].c);
      chk($sformatf("v%0d zero", i), zero, vecs[i].z);
      chk($sformatf("v%0d busy at done", i), busy, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done one cycle", i), done, 0);
      chk($sformatf("v%0d y held", i), y, vecs[i].y);
    end

    // Start while busy is ignored; abort kills the operation without done
    launch(2'b00, 16'h1234, 5'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mode = 2'b11; a = 16'hFFFF; shamt = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort y kept", y, 16'h2341);
    chk("abort carry kept", carry, 1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort no late done", seen, 0);
    launch(2'b00, 16'h1234, 5'd8);
    wait_done(lat);
    chk("post-abort latency", lat, 9);
    chk("post-abort y", y, 16'h3400);
    chk("post-abort carry", carry, 0);

    // Abort in IDLE blocks a same-cycle start
    start = 1'b1; abort = 1'b1; mode = 2'b00; a = 16'h0001; shamt = 5'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("idle abort blocks start", busy, 0);
    @(posedge clk); #1;
    chk("idle abort no done", done, 0);

    // Abort coinciding with cnt==0 wins over completion
    launch(2'b00, 16'hAAAA, 5'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort@cnt0 done", done, 0);
    chk("abort@cnt0 busy", busy, 0);
    chk("abort@cnt0 y", y, 16'h3400);

    // Back-to-back: second start accepted in the done cycle
    launch(2'b00, 16'h0001, 5'd2);
    wait_done(lat);
    chk("b2b first latency", lat, 3);
    chk("b2b first y", y, 16'h0004);
    launch(2'b11, 16'h8001, 5'd1);
    chk("b2b second accepted", busy, 1);
    wait_done(lat);
    chk("b2b second latency", lat, 2);
    chk("b2b second y", y, 16'h0003);
    chk("b2b second carry", carry, 1);

    // Asynchronous reset between edges, mid-operation
    launch(2'b00, 16'hFFFF, 5'd10);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst busy",  busy,  0);
    chk("async rst done",  done,  0);
    chk("async rst y",     y,     0);
    chk("async rst carry", carry, 0);
    chk("async rst zero",  zero,  1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("async rst no done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
